// File: rtl/conv_frame_writer.sv
// Frame-capture sink: drops warm-up and wrap-around pixels from the convolution
// stream and writes interior pixels to frame memory through a small write FIFO.
module conv_frame_writer #(
    parameter int WORD_SIZE  = 8,
    parameter int ROW_SIZE   = 540,
    parameter int NUM_ROWS   = 540,
    parameter int SKIP       = 1085,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                               clk,
    input  logic                                               rst_n,
    input  logic                                               start,
    input  logic                                               in_valid,
    input  logic [WORD_SIZE-1:0]                               in_pixel,
    output logic                                               wr_valid,
    input  logic                                               wr_ready,
    output logic [$clog2((ROW_SIZE-2)*(NUM_ROWS-2))-1:0]       wr_addr,
    output logic [WORD_SIZE-1:0]                               wr_data,
    output logic                                               busy,
    output logic                                               frame_done,
    output logic                                               overflow
);

    localparam int ADDR_W = $clog2((ROW_SIZE-2)*(NUM_ROWS-2));
    localparam int COL_W  = $clog2(ROW_SIZE);
    localparam int ROW_W  = $clog2(NUM_ROWS);
    localparam int SKIP_W = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_CAPTURE,
        ST_DRAIN
    } state_t;

    state_t              state_q, state_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [ADDR_W-1:0]    addr_mem [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] data_mem [FIFO_DEPTH];

    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_wr;

    assign fifo_full = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign pop       = wr_valid && wr_ready;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign fifo_wr   = push && (!fifo_full || pop);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d = state_q;
        skip_d  = skip_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;
        push    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    skip_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    ovf_d   = 1'b0;
                    state_d = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
                end
            end
            ST_SKIP: begin
                if (in_valid) begin
                    skip_d = skip_q + 1'b1;
                    if (skip_q == SKIP_W'(SKIP - 1)) state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (in_valid) begin
                    if (col_q == COL_W'(ROW_SIZE - 1)) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    // The last two columns of each row are window wrap-around garbage.
                    if (col_q < COL_W'(ROW_SIZE - 2)) begin
                        push   = 1'b1;
                        addr_d = addr_q + 1'b1;
                        if (fifo_full && !pop) ovf_d = 1'b1;
                        if (row_q == ROW_W'(NUM_ROWS - 3) && col_q == COL_W'(ROW_SIZE - 3))
                            state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_q == '0 || (cnt_q == CNT_W'(1) && pop)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        unique case ({fifo_wr, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            skip_q   <= '0;
            col_q    <= '0;
            row_q    <= '0;
            addr_q   <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            skip_q   <= skip_d;
            col_q    <= col_d;
            row_q    <= row_d;
            addr_q   <= addr_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // NOTE: FIFO storage is not reset; the outputs are masked by wr_valid so stale entries never show.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            addr_mem[wr_ptr_q] <= addr_q;
            data_mem[wr_ptr_q] <= in_pixel;
        end
    end

    assign wr_valid   = (cnt_q != '0);
    assign wr_addr    = wr_valid ? addr_mem[rd_ptr_q] : '0;
    assign wr_data    = wr_valid ? data_mem[rd_ptr_q] : '0;
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = done_q;
    assign overflow   = ovf_q;

endmodule
